// File: rtl/branch_predict_unit.sv
// IF-stage BTB lookup with an IF->ID prediction register and ID-stage resolution.
// Mispredicts flush IF and supply the corrected PC; the BTB is trained in the following edge.
module branch_predict_unit #(
   parameter int ENTRIES  = 64,
   parameter int CNT_W    = 2,
   parameter int CNT_INIT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pcF,
   input  logic        stallF,
   input  logic        stallD,
   input  logic        flushD,
   output logic        pred_takenF,
   output logic [31:0] pred_targetF,
   input  logic [31:0] pcD,
   input  logic        branchD,
   input  logic        takenD,
   input  logic [31:0] targetD,
   output logic        mispredictD,
   output logic [31:0] redirect_pcD
);
   localparam int INDEX_W     = $clog2(ENTRIES);
   localparam int TAG_W       = 30 - INDEX_W;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;
   localparam int CNT_ALLOC_I = (CNT_INIT + 1 > CNT_MAX) ? CNT_MAX : CNT_INIT + 1;
   localparam logic [CNT_W-1:0] CNT_RST   = CNT_W'(CNT_INIT);
   localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_W'(CNT_ALLOC_I);
   localparam logic [CNT_W-1:0] CNT_SAT   = '1;

   logic [ENTRIES-1:0] valid;
   logic [TAG_W-1:0]   tag_mem [ENTRIES];
   logic [31:0]        tgt_mem [ENTRIES];
   logic [CNT_W-1:0]   cnt_mem [ENTRIES];

   logic [INDEX_W-1:0] idx_f, idx_d;
   logic [TAG_W-1:0]   tag_f, tag_d;
   logic               hit_f, hit_d, alias_d, upd;
   logic               predD;
   logic [31:0]        ptgtD;
   logic [CNT_W-1:0]   cnt_cur, cnt_inc, cnt_dec;
   logic               unused_ok;

   assign unused_ok = ^{pcF[1:0], pcD[1:0]};

   assign idx_f = pcF[INDEX_W+1:2];
   assign tag_f = pcF[31:INDEX_W+2];
   assign idx_d = pcD[INDEX_W+1:2];
   assign tag_d = pcD[31:INDEX_W+2];

   // Combinational read: a same-cycle update of this index is seen only after the edge.
   assign hit_f        = valid[idx_f] && (tag_mem[idx_f] == tag_f);
   assign pred_takenF  = hit_f && cnt_mem[idx_f][CNT_W-1];
   assign pred_targetF = tgt_mem[idx_f];

   assign hit_d   = valid[idx_d] && (tag_mem[idx_d] == tag_d);
   assign alias_d = !branchD && predD;
   assign upd     = branchD && !stallD;

   assign mispredictD = !stallD &&
      ((branchD && ((takenD != predD) || (takenD && predD && (targetD != ptgtD)))) || alias_d);
   // Aliased non-branch resumes at the next sequential instruction, not past a delay slot.
   assign redirect_pcD = alias_d ? (pcD + 32'd4) : (takenD ? targetD : (pcD + 32'd8));

   assign cnt_cur = cnt_mem[idx_d];
   assign cnt_inc = (cnt_cur == CNT_SAT) ? cnt_cur : cnt_cur + 1'b1;
   assign cnt_dec = (cnt_cur == '0) ? cnt_cur : cnt_cur - 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         predD <= 1'b0;
         ptgtD <= '0;
      end else if (flushD || mispredictD) begin
         predD <= 1'b0;
         ptgtD <= '0;
      end else if (!stallD) begin
         predD <= stallF ? 1'b0 : pred_takenF;
         ptgtD <= stallF ? 32'd0 : pred_targetF;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= '0;
         for (int i = 0; i < ENTRIES; i++) cnt_mem[i] <= CNT_RST;
      end else if (upd) begin
         if (hit_d) begin
            cnt_mem[idx_d] <= takenD ? cnt_inc : cnt_dec;
         end else if (takenD) begin
            valid[idx_d]   <= 1'b1;
            cnt_mem[idx_d] <= CNT_ALLOC;
         end
      end else if (!stallD && alias_d) begin
         valid[idx_d] <= 1'b0;
      end
   end

   // Tag/target need no reset: they are only observed through a set valid bit.
   always_ff @(posedge clk) begin
      if (upd && takenD) begin
         tgt_mem[idx_d] <= targetD;
         if (!hit_d) tag_mem[idx_d] <= tag_d;
      end
   end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomized and directed bench for branch_predict_unit with a queue-based scoreboard
// fed by a table-level reference model of the BTB and prediction register.
module tb_branch_predict_unit;
   localparam int ENTRIES  = 64;
   localparam int CNT_W    = 2;
   localparam int CNT_INIT = 1;
   localparam int IW       = $clog2(ENTRIES);
   localparam int CMAX     = (1 << CNT_W) - 1;
   localparam int THRESH   = 1 << (CNT_W - 1);

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pcF = '0;
   logic        stallF = 1'b0, stallD = 1'b0, flushD = 1'b0;
   logic        pred_takenF;
   logic [31:0] pred_targetF;
   logic [31:0] pcD = '0;
   logic        branchD = 1'b0, takenD = 1'b0;
   logic [31:0] targetD = '0;
   logic        mispredictD;
   logic [31:0] redirect_pcD;

   branch_predict_unit #(.ENTRIES(ENTRIES), .CNT_W(CNT_W), .CNT_INIT(CNT_INIT)) dut (
      .clk(clk), .rst(rst), .pcF(pcF), .stallF(stallF), .stallD(stallD), .flushD(flushD),
      .pred_takenF(pred_takenF), .pred_targetF(pred_targetF), .pcD(pcD), .branchD(branchD),
      .takenD(takenD), .targetD(targetD), .mispredictD(mispredictD), .redirect_pcD(redirect_pcD)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      bit          pt;
      logic [31:0] ptg;
      bit          mis;
      logic [31:0] rpc;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int failures = 0;
   int step_no = 0;

   // Reference model: one record per table slot, counters as plain integers.
   bit          m_valid [ENTRIES];
   logic [31:0] m_tag   [ENTRIES];
   logic [31:0] m_tgt   [ENTRIES];
   int          m_cnt   [ENTRIES];
   bit          m_pred;
   logic [31:0] m_ptgt;

   function automatic int midx(input logic [31:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   function automatic logic [31:0] mtag(input logic [31:0] pc);
      return pc >> (IW + 2);
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      return m_valid[midx(pc)] && (m_tag[midx(pc)] == mtag(pc));
   endfunction

   task automatic m_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 0;
         m_cnt[i]   = CNT_INIT;
      end
      m_pred = 0;
      m_ptgt = '0;
   endtask

   task automatic step(input bit r, input logic [31:0] pf, input bit sf, input bit sd,
                       input bit fd, input logic [31:0] pd, input bit br, input bit tk,
                       input logic [31:0] td);
      exp_t e;
      int i;
      rst = r; pcF = pf; stallF = sf; stallD = sd; flushD = fd;
      pcD = pd; branchD = br; takenD = tk; targetD = td;
      if (r) m_reset();
      i = midx(pf);
      e.id  = step_no;
      e.pt  = m_hit(pf) && (m_cnt[i] >= THRESH);
      e.ptg = m_tgt[i];
      if (sd)      e.mis = 0;
      else if (br) e.mis = (tk != m_pred) || (tk && m_pred && (td != m_ptgt));
      else         e.mis = m_pred;
      e.rpc = (!br && m_pred) ? pd + 32'd4 : (tk ? td : pd + 32'd8);
      q.push_back(e);
      if (!r) begin
         i = midx(pd);
         if (!sd && br) begin
            if (m_hit(pd)) begin
               m_cnt[i] = tk ? ((m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1)
                             : ((m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1);
               if (tk) m_tgt[i] = td;
            end else if (tk) begin
               m_valid[i] = 1;
               m_tag[i]   = mtag(pd);
               m_tgt[i]   = td;
               m_cnt[i]   = (CNT_INIT + 1 > CMAX) ? CMAX : CNT_INIT + 1;
            end
         end else if (!sd && m_pred) begin
            m_valid[i] = 0;
         end
         if (fd || e.mis) begin
            m_pred = 0; m_ptgt = '0;
         end else if (!sd) begin
            m_pred = sf ? 1'b0 : e.pt;
            m_ptgt = sf ? 32'd0 : (e.pt ? e.ptg : pred_targetF);
         end
      end
      step_no++;
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares each cycle's DUT outputs against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (pred_takenF !== e.pt) begin
               failures++;
               $display("FAIL pred_taken step=%0d got=%0b want=%0b", e.id, pred_takenF, e.pt);
            end
            if (e.pt) begin
               checks++;
               if (pred_targetF !== e.ptg) begin
                  failures++;
                  $display("FAIL pred_target step=%0d got=%h want=%h", e.id, pred_targetF, e.ptg);
               end
            end
            checks++;
            if (mispredictD !== e.mis) begin
               failures++;
               $display("FAIL mispredict step=%0d got=%0b want=%0b", e.id, mispredictD, e.mis);
            end
            checks++;
            if (redirect_pcD !== e.rpc) begin
               failures++;
               $display("FAIL redirect_pc step=%0d got=%h want=%h", e.id, redirect_pcD, e.rpc);
            end
         end
      end
   end

   logic [31:0] pool [8];
   logic [31:0] tpool [4];

   initial begin
      logic [31:0] a, b;
      m_reset();
      @(posedge clk); #1;
      a = 32'h0040_0010;
      b = a + 4 * ENTRIES;
      step(1, a, 0, 0, 0, 32'h0, 0, 0, 32'h0);
      // Allocate, then train down to not-taken.
      step(0, a, 0, 0, 0, a, 1, 1, 32'h0040_0040);
      step(0, a, 0, 0, 0, 32'h0, 0, 0, 32'h0);
      step(0, 32'h100, 0, 0, 0, a, 1, 0, 32'h0040_0040);
      step(0, 32'h100, 0, 0, 0, a, 1, 0, 32'h0040_0040);
      step(0, a, 0, 0, 0, 32'h0, 0, 0, 32'h0);
      // Saturate, then a single not-taken still predicts taken.
      for (int k = 0; k < 6; k++) step(0, 32'h100, 0, 0, 0, a, 1, 1, 32'h0040_0040);
      step(0, 32'h100, 0, 0, 0, a, 1, 0, 32'h0040_0040);
      step(0, a, 0, 0, 0, 32'h0, 0, 0, 32'h0);
      // Aliasing: tag miss on b, then a predicted-taken non-branch invalidates.
      step(0, b, 0, 0, 0, 32'h0, 0, 0, 32'h0);
      step(0, a, 0, 0, 0, 32'h0, 0, 0, 32'h0);
      step(0, 32'h100, 0, 0, 0, a, 0, 0, 32'h0);
      step(0, a, 0, 0, 0, 32'h0, 0, 0, 32'h0);
      // Stall holds the prediction register, flush clears it.
      step(0, 32'h100, 0, 0, 0, 32'h0040_0020, 1, 1, 32'h0040_0080);
      step(0, 32'h0040_0020, 0, 0, 0, 32'h0, 0, 0, 32'h0);
      for (int k = 0; k < 3; k++) step(0, 32'h200, 0, 1, 0, 32'h0040_0020, 1, 0, 32'h0040_0080);
      step(0, 32'h200, 0, 1, 1, 32'h0040_0020, 0, 0, 32'h0);
      step(0, 32'h0040_0020, 0, 0, 0, 32'h0040_0020, 0, 0, 32'h0);
      step(0, 32'h0040_0020, 1, 0, 0, 32'h0, 0, 0, 32'h0);
      step(0, 32'h300, 0, 0, 0, 32'h0040_0020, 1, 1, 32'h0040_0080);
      // Reset with 10 live entries, then read-before-write on one index.
      for (int k = 0; k < 10; k++) step(0, 32'h0, 0, 0, 0, 32'h0040_1000 + 4 * k, 1, 1, 32'h0040_2000 + 4 * k);
      step(1, 32'h0040_1000, 0, 1, 0, 32'h0, 0, 0, 32'h0);
      for (int k = 0; k < 10; k++) step(0, 32'h0040_1000 + 4 * k, 0, 0, 0, 32'h0, 0, 0, 32'h0);
      step(0, 32'h0040_1008, 0, 0, 0, 32'h0040_1008, 1, 1, 32'h0040_3000);
      step(0, 32'h0040_1008, 0, 0, 0, 32'h0, 0, 0, 32'h0);
      step(0, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 1, 0, 32'h0);
      // Randomized traffic over a small PC pool so entries collide and alias.
      for (int k = 0; k < 8; k++) pool[k] = 32'h0040_0000 + 4 * (k % 4) + ((k >= 4) ? 4 * ENTRIES : 0);
      pool[7] = 32'hFFFF_FFF8;
      for (int k = 0; k < 4; k++) tpool[k] = 32'h0050_0000 + 32'h40 * k;
      for (int k = 0; k < 500; k++) begin
         step($urandom_range(0, 99) == 0, pool[$urandom_range(0, 7)],
              $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
              pool[$urandom_range(0, 7)], $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
              tpool[$urandom_range(0, 3)]);
      end
      @(negedge clk); #1;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d pending want=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
